// File: rtl/hazard_controller_if.sv
// Decode-side hazard information in, pipeline stall/flush/forward controls
// and event counters out, for the hazard controller.
interface hazard_controller_if #(
  parameter int CNT_W = 8
);
  logic             id_valid;
  logic [2:0]       id_rs1;
  logic [2:0]       id_rs2;
  logic [2:0]       id_rd;
  logic             id_uses_rs1;
  logic             id_uses_rs2;
  logic             id_reg_write;
  logic             id_mem_read;
  logic             ex_mispredict;
  logic             stall;
  logic             flush;
  logic [1:0]       forwardA;
  logic [1:0]       forwardB;
  logic [1:0]       ctrl_state;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output id_valid, id_rs1, id_rs2, id_rd, id_uses_rs1, id_uses_rs2,
           id_reg_write, id_mem_read, ex_mispredict,
    input  stall, flush, forwardA, forwardB, ctrl_state, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_rd, id_uses_rs1, id_uses_rs2,
           id_reg_write, id_mem_read, ex_mispredict,
    output stall, flush, forwardA, forwardB, ctrl_state, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_controller.sv
// Pipeline hazard controller: shadows in-flight destinations (EX/MEM/WB),
// raises load-use stalls, mispredict flushes and operand forwarding selects.
module hazard_controller #(
  parameter int FLUSH_CYCLES = 1,
  parameter bit R0_HARDWIRED = 1'b1,
  parameter int CNT_W        = 8
) (
  input logic          clk,
  input logic          reset,
  hazard_controller_if.slave hz
);

  typedef enum logic [1:0] {
    ST_RUN        = 2'b00,
    ST_LOAD_STALL = 2'b01,
    ST_FLUSH      = 2'b10
  } state_t;

  typedef struct packed {
    logic       valid;
    logic [2:0] rs1;
    logic [2:0] rs2;
    logic       use1;
    logic       use2;
    logic [2:0] rd;
    logic       we;
    logic       mr;
  } ex_stage_t;

  typedef struct packed {
    logic [2:0] rd;
    logic       we;
    logic       mr;
  } mem_stage_t;

  typedef struct packed {
    logic [2:0] rd;
    logic       we;
  } wb_stage_t;

  localparam ex_stage_t EX_BUBBLE_C = '{valid: 1'b0, rs1: 3'd0, rs2: 3'd0, use1: 1'b0,
                                        use2: 1'b0, rd: 3'd0, we: 1'b0, mr: 1'b0};
  localparam mem_stage_t MEM_BUBBLE_C = '{rd: 3'd0, we: 1'b0, mr: 1'b0};
  localparam wb_stage_t  WB_BUBBLE_C  = '{rd: 3'd0, we: 1'b0};
  localparam logic [1:0] FLUSH_LOAD_C = 2'(FLUSH_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX_C = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE_C = {{(CNT_W-1){1'b0}}, 1'b1};

  ex_stage_t        ex_r, ex_nx_s;
  mem_stage_t       mem_r;
  wb_stage_t        wb_r;
  state_t           state_r, state_nx_s;
  logic [1:0]       fcnt_r, fcnt_nx_s;
  logic [CNT_W-1:0] stall_cnt_r, flush_cnt_r;
  logic             ld_hz_s, mp_s, flush_s, stall_s;
  logic [1:0]       fwd_a_s, fwd_b_s;

  function automatic logic r0_ok(input logic [2:0] rd);
    return !(R0_HARDWIRED && (rd == 3'd0));
  endfunction

  // MEM (ALU results only) beats WB; loads still sitting in MEM never forward
  function automatic logic [1:0] fwd_sel(input logic uses, input logic [2:0] rs,
                                         input mem_stage_t mem, input wb_stage_t wb);
    logic [1:0] sel;
    sel = 2'b00;
    if (uses && mem.we && !mem.mr && (mem.rd == rs) && r0_ok(rs)) begin
      sel = 2'b01;
    end else if (wb.we && (wb.rd == rs) && r0_ok(rs)) begin
      sel = 2'b10;
    end else begin
      sel = 2'b00;
    end
    return sel;
  endfunction

  // Load-use hazard against the load currently in EX
  always_comb begin
    ld_hz_s = 1'b0;
    if (hz.id_valid && ex_r.valid && ex_r.mr && ex_r.we && r0_ok(ex_r.rd)) begin
      ld_hz_s = (hz.id_uses_rs1 && (hz.id_rs1 == ex_r.rd)) ||
                (hz.id_uses_rs2 && (hz.id_rs2 == ex_r.rd));
    end else begin
      ld_hz_s = 1'b0;
    end
  end

  assign mp_s    = hz.ex_mispredict & ex_r.valid;
  assign flush_s = (state_r == ST_FLUSH) | mp_s;
  assign stall_s = ld_hz_s & ~flush_s;

  // Next EX shadow: decode instruction, or a bubble when held or killed
  always_comb begin
    ex_nx_s = EX_BUBBLE_C;
    if (hz.id_valid && !stall_s && !flush_s) begin
      ex_nx_s = '{valid: 1'b1, rs1: hz.id_rs1, rs2: hz.id_rs2, use1: hz.id_uses_rs1,
                  use2: hz.id_uses_rs2, rd: hz.id_rd, we: hz.id_reg_write,
                  mr: hz.id_mem_read};
    end else begin
      ex_nx_s = EX_BUBBLE_C;
    end
  end

  // Shadow pipeline registers; MEM and WB always advance
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_r  <= EX_BUBBLE_C;
      mem_r <= MEM_BUBBLE_C;
      wb_r  <= WB_BUBBLE_C;
    end else begin
      ex_r  <= ex_nx_s;
      mem_r <= '{rd: ex_r.rd, we: ex_r.we, mr: ex_r.mr};
      wb_r  <= '{rd: mem_r.rd, we: mem_r.we};
    end
  end

  // Controller next state; the mispredict cycle itself is the first flush cycle
  always_comb begin
    state_nx_s = state_r;
    fcnt_nx_s  = fcnt_r;
    case (state_r)
      ST_RUN: begin
        if (mp_s) begin
          state_nx_s = (FLUSH_LOAD_C != 2'd0) ? ST_FLUSH : ST_RUN;
          fcnt_nx_s  = FLUSH_LOAD_C;
        end else if (ld_hz_s) begin
          state_nx_s = ST_LOAD_STALL;
        end else begin
          state_nx_s = ST_RUN;
        end
      end
      ST_LOAD_STALL: begin
        if (mp_s) begin
          state_nx_s = (FLUSH_LOAD_C != 2'd0) ? ST_FLUSH : ST_RUN;
          fcnt_nx_s  = FLUSH_LOAD_C;
        end else begin
          state_nx_s = ST_RUN;
        end
      end
      ST_FLUSH: begin
        if (fcnt_r <= 2'd1) begin
          state_nx_s = ST_RUN;
          fcnt_nx_s  = 2'd0;
        end else begin
          state_nx_s = ST_FLUSH;
          fcnt_nx_s  = fcnt_r - 2'd1;
        end
      end
      default: begin
        state_nx_s = ST_RUN;
        fcnt_nx_s  = 2'd0;
      end
    endcase
  end

  // Controller state and flush countdown registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_RUN;
      fcnt_r  <= 2'd0;
    end else begin
      state_r <= state_nx_s;
      fcnt_r  <= fcnt_nx_s;
    end
  end

  // Operand forwarding selects for the EX instruction
  always_comb begin
    fwd_a_s = 2'b00;
    fwd_b_s = 2'b00;
    if (ex_r.valid) begin
      fwd_a_s = fwd_sel(ex_r.use1, ex_r.rs1, mem_r, wb_r);
      fwd_b_s = fwd_sel(ex_r.use2, ex_r.rs2, mem_r, wb_r);
    end else begin
      fwd_a_s = 2'b00;
      fwd_b_s = 2'b00;
    end
  end

  // Saturating stall-cycle and mispredict counters
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_r <= {CNT_W{1'b0}};
      flush_cnt_r <= {CNT_W{1'b0}};
    end else begin
      if (stall_s && (stall_cnt_r != CNT_MAX_C)) begin
        stall_cnt_r <= stall_cnt_r + CNT_ONE_C;
      end
      if (mp_s && (flush_cnt_r != CNT_MAX_C)) begin
        flush_cnt_r <= flush_cnt_r + CNT_ONE_C;
      end
    end
  end

  assign hz.stall      = stall_s;
  assign hz.flush      = flush_s;
  assign hz.forwardA   = fwd_a_s;
  assign hz.forwardB   = fwd_b_s;
  assign hz.ctrl_state = state_r;
  assign hz.stall_cnt  = stall_cnt_r;
  assign hz.flush_cnt  = flush_cnt_r;

endmodule

// File: tb/tb_hazard_controller.sv
// Directed bench for hazard_controller (FLUSH_CYCLES=2): inputs change and
// outputs are sampled on the falling edge, state advances on the rising edge.
module tb_hazard_controller;

  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  hazard_controller_if #(.CNT_W(8)) bus ();

  hazard_controller #(
    .FLUSH_CYCLES(2),
    .R0_HARDWIRED(1'b1),
    .CNT_W(8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .hz    (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk(input string tag, input logic st, input logic fl,
                     input logic [1:0] fa, input logic [1:0] fb, input logic [1:0] cs);
    check({tag, ".stall"},      32'(bus.stall),      32'(st));
    check({tag, ".flush"},      32'(bus.flush),      32'(fl));
    check({tag, ".forwardA"},   32'(bus.forwardA),   32'(fa));
    check({tag, ".forwardB"},   32'(bus.forwardB),   32'(fb));
    check({tag, ".ctrl_state"}, 32'(bus.ctrl_state), 32'(cs));
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic drv(input logic v, input logic [2:0] rd, input logic [2:0] rs1,
                     input logic [2:0] rs2, input logic u1, input logic u2,
                     input logic we, input logic mr);
    bus.id_valid     = v;
    bus.id_rd        = rd;
    bus.id_rs1       = rs1;
    bus.id_rs2       = rs2;
    bus.id_uses_rs1  = u1;
    bus.id_uses_rs2  = u2;
    bus.id_reg_write = we;
    bus.id_mem_read  = mr;
  endtask

  task automatic alu(input logic [2:0] rd, input logic [2:0] rs1, input logic [2:0] rs2);
    drv(1'b1, rd, rs1, rs2, 1'b1, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic ld(input logic [2:0] rd, input logic [2:0] rs1);
    drv(1'b1, rd, rs1, 3'd0, 1'b1, 1'b0, 1'b1, 1'b1);
  endtask

  task automatic nop();
    drv(1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      cyc();
      nop();
    end
  endtask

  task automatic rnd();
    drv(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
        3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
        1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    bus.ex_mispredict = 1'($urandom_range(0, 1));
  endtask

  initial begin
    reset = 1'b1;
    rnd();

    // reset held for two edges with random inputs
    for (int i = 0; i < 2; i++) begin
      cyc();
      rnd();
      #1;
      chk("reset", 1'b0, 1'b0, 2'b00, 2'b00, 2'b00);
      check("reset.stall_cnt", 32'(bus.stall_cnt), 32'd0);
      check("reset.flush_cnt", 32'(bus.flush_cnt), 32'd0);
    end
    reset = 1'b0;
    nop();
    bus.ex_mispredict = 1'b0;
    cyc();
    #1;
    chk("post_reset", 1'b0, 1'b0, 2'b00, 2'b00, 2'b00);
    check("post_reset.stall_cnt", 32'(bus.stall_cnt), 32'd0);
    idle(2);

    // ALU result forwarded from MEM
    cyc(); alu(3'd3, 3'd1, 3'd2);
    cyc(); alu(3'd4, 3'd3, 3'd6);
    cyc(); nop(); #1;
    chk("mem_fwd", 1'b0, 1'b0, 2'b01, 2'b00, 2'b00);
    idle(3);

    // two writers of r2: the newer one in MEM wins
    cyc(); alu(3'd2, 3'd1, 3'd1);
    cyc(); alu(3'd2, 3'd3, 3'd3);
    cyc(); alu(3'd4, 3'd7, 3'd2);
    cyc(); nop(); #1;
    chk("mem_over_wb", 1'b0, 1'b0, 2'b00, 2'b01, 2'b00);
    idle(3);

    // one NOP between writer and reader: forward from WB
    cyc(); alu(3'd2, 3'd1, 3'd1);
    cyc(); nop();
    cyc(); alu(3'd4, 3'd7, 3'd2);
    cyc(); nop(); #1;
    chk("wb_fwd", 1'b0, 1'b0, 2'b00, 2'b10, 2'b00);
    idle(3);

    // load-use: one stall cycle, then forward from WB
    cyc(); ld(3'd5, 3'd1);
    cyc(); alu(3'd6, 3'd5, 3'd1); #1;
    chk("lu_detect", 1'b1, 1'b0, 2'b00, 2'b00, 2'b00);
    cyc(); alu(3'd6, 3'd5, 3'd1); #1;
    chk("lu_hold", 1'b0, 1'b0, 2'b00, 2'b00, 2'b01);
    check("lu_hold.stall_cnt", 32'(bus.stall_cnt), 32'd1);
    cyc(); nop(); #1;
    chk("lu_fwd", 1'b0, 1'b0, 2'b10, 2'b00, 2'b00);
    check("lu_fwd.stall_cnt", 32'(bus.stall_cnt), 32'd1);
    idle(3);

    // mispredict on a load in EX while decode reads it
    cyc(); alu(3'd4, 3'd1, 3'd1);
    cyc(); ld(3'd5, 3'd1);
    cyc(); drv(1'b1, 3'd6, 3'd5, 3'd4, 1'b1, 1'b1, 1'b1, 1'b0);
    bus.ex_mispredict = 1'b1; #1;
    chk("mp_first", 1'b0, 1'b1, 2'b00, 2'b00, 2'b00);
    check("mp_first.flush_cnt", 32'(bus.flush_cnt), 32'd0);
    cyc(); nop(); #1;
    chk("mp_second", 1'b0, 1'b1, 2'b00, 2'b00, 2'b10);
    check("mp_second.flush_cnt", 32'(bus.flush_cnt), 32'd1);
    cyc(); nop(); #1;
    chk("mp_done", 1'b0, 1'b0, 2'b00, 2'b00, 2'b00);
    check("mp_done.flush_cnt", 32'(bus.flush_cnt), 32'd1);
    check("mp_done.stall_cnt", 32'(bus.stall_cnt), 32'd1);
    bus.ex_mispredict = 1'b0;
    idle(3);

    // r0 is never forwarded nor a load-use source
    cyc(); alu(3'd0, 3'd1, 3'd1);
    cyc(); alu(3'd6, 3'd0, 3'd0);
    cyc(); nop(); #1;
    chk("r0_fwd", 1'b0, 1'b0, 2'b00, 2'b00, 2'b00);
    idle(3);
    cyc(); ld(3'd0, 3'd1);
    cyc(); alu(3'd6, 3'd0, 3'd1); #1;
    chk("r0_load", 1'b0, 1'b0, 2'b00, 2'b00, 2'b00);
    cyc(); nop(); #1;
    check("r0_load.ctrl_state", 32'(bus.ctrl_state), 32'd0);
    check("r0_load.stall_cnt", 32'(bus.stall_cnt), 32'd1);
    idle(3);

    // back-to-back dependent loads stall every other cycle: 300 stalls
    for (int i = 0; i < 600; i++) begin
      cyc();
      ld(3'd5, 3'd5);
      if (i == 400) begin
        #1;
        check("sat_mid.stall_cnt", 32'(bus.stall_cnt), 32'd201);
      end
    end
    cyc(); nop(); #1;
    check("sat.stall_cnt", 32'(bus.stall_cnt), 32'd255);
    idle(2);

    // reset in the mispredict cycle aborts the flush
    cyc(); alu(3'd4, 3'd1, 3'd1);
    cyc(); nop(); bus.ex_mispredict = 1'b1; reset = 1'b1;
    cyc(); reset = 1'b0; bus.ex_mispredict = 1'b0; nop(); #1;
    chk("rst_abort", 1'b0, 1'b0, 2'b00, 2'b00, 2'b00);
    check("rst_abort.stall_cnt", 32'(bus.stall_cnt), 32'd0);
    check("rst_abort.flush_cnt", 32'(bus.flush_cnt), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hazard_controller.md
Name: hazard_controller

Overview:
- Central pipeline controller for the 8-bit, 16-bit-instruction, 8-register pipeline.
- Sits beside fetch, decode and execute. It tracks the destination registers of in-flight instructions in internal shadow stages (EX, MEM, WB).
- Drives the pipeline's stall, flush and forwardA/forwardB controls, which are currently tied off.
- Sequences load-use stalls and branch-mispredict flushes through a small state machine, and keeps saturating event counters.

Parameters:
- FLUSH_CYCLES, 1: cycles flush stays high after a mispredict (1..3).
- R0_HARDWIRED, 1: when 1, register 0 is never a hazard/forward source.
- CNT_W, 8: width of the performance counters.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- id_valid  in  1  decode stage holds a real instruction.
- id_rs1  in  3  source register 1 of the decode instruction.
- id_rs2  in  3  source register 2 of the decode instruction.
- id_rd  in  3  destination register of the decode instruction.
- id_uses_rs1  in  1  decode instruction reads rs1.
- id_uses_rs2  in  1  decode instruction reads rs2.
- id_reg_write  in  1  decode instruction writes rd.
- id_mem_read  in  1  decode instruction is a load.
- ex_mispredict  in  1  branch in EX resolved opposite to predict_taken.
- stall  out  1  hold PC and IF/ID; insert a bubble into EX.
- flush  out  1  kill the IF/ID and ID/EX contents.
- forwardA  out  2  operand A source for the EX instruction: 00 register file, 01 MEM alu_result, 10 WB write_data.
- forwardB  out  2  operand B source, same encoding as forwardA.
- ctrl_state  out  2  00 RUN, 01 LOAD_STALL, 10 FLUSH.
- stall_cnt  out  CNT_W  saturating count of stall cycles.
- flush_cnt  out  CNT_W  saturating count of mispredict events.

Behaviour:
- Reset:
  - All shadow stages become invalid (valid=0, we=0, mr=0).
  - stall=0, flush=0, forwardA=forwardB=00, ctrl_state=RUN, counters=0.
  - Any reset mid-stall or mid-flush aborts the operation immediately; the next cycle is RUN.
- Shadow pipeline, every edge:
  - WB <= MEM and MEM <= EX, always (never stalled).
  - EX <= ID fields (valid, rs1, rs2, uses, rd, we, mr) only when stall=0, flush=0 and id_valid=1. Otherwise EX <= bubble (valid=0, we=0, mr=0).
- Load-use hazard (combinational, from ID inputs and EX shadow): ld_hz = id_valid & ex_valid & ex_mr & ex_we & (id_uses_rs1 & id_rs1==ex_rd | id_uses_rs2 & id_rs2==ex_rd). The hazard is masked when ex_rd==0 and R0_HARDWIRED=1.
- Mispredict qualification: mp = ex_mispredict & ex_valid. ex_mispredict is ignored while EX holds a bubble.
- FSM:
  - RUN:
    - mp -> FLUSH, with flush counter loaded with FLUSH_CYCLES-1.
    - else ld_hz -> LOAD_STALL.
    - else stay in RUN.
  - LOAD_STALL: lasts exactly one cycle, then -> RUN. If mp occurs in this cycle, go to FLUSH instead.
  - FLUSH: count down; at 0 -> RUN. A new mp cannot occur here because EX holds bubbles.
- Outputs (combinational from state and inputs):
  - flush = (state==FLUSH) | mp. It is high in the same cycle as the mispredict, then for FLUSH_CYCLES-1 further cycles.
  - stall = ld_hz & ~flush. Flush has priority over stall.
  - ctrl_state reflects the registered state.
- Forwarding, for the EX instruction, per operand (operand A shown; B is identical using rs2):
  - If ex_uses_rs1 & mem_we & mem_rd==ex_rs1 & ~mem_mr: forwardA = 01.
  - Else if wb_we & wb_rd==ex_rs1: forwardA = 10.
  - Else forwardA = 00.
  - The newer stage (MEM) wins. A load in MEM is never forwarded as 01.
  - Register 0 is excluded when R0_HARDWIRED=1.
  - forwardA/forwardB = 00 whenever ex_valid=0.
- Counters:
  - stall_cnt increments each cycle stall=1.
  - flush_cnt increments once per mp.
  - Both saturate at all-ones and never wrap.

Test Plan:
- Reset:
  - Assert reset for 2 cycles with random inputs.
  - Required: all outputs 0 / 00 and ctrl_state=00 during reset and on the first cycle after.
- ALU forward from MEM:
  - Issue ADD r3<=..., then SUB reading rs1=r3.
  - Required: when SUB is in EX, forwardA=01, forwardB=00, stall=0.
- WB forward and priority:
  - Issue writes to r2 at t and t+1, then a reader of rs2=r2.
  - Required: forwardB=01 (newest writer, in MEM).
  - With one intervening NOP instead, required: forwardB=10.
- Load-use:
  - Issue LOAD r5 then ADD reading r5.
  - Required: stall=1 for exactly 1 cycle, ctrl_state=01, stall_cnt=1.
  - Next cycle, with ADD in EX: forwardA=10.
- Mispredict:
  - ex_mispredict=1 with a valid EX, FLUSH_CYCLES=2.
  - Required: flush=1 for 2 cycles, EX then holds a bubble, flush_cnt=1.
  - Simultaneous ld_hz gives stall=0.
- Saturation / R0:
  - Force 300 stall cycles. Required: stall_cnt=255.
  - Writer rd=0 followed by a reader of r0. Required: forwardA=00 and no stall.
